// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring
// divide, one bit per cycle, with a single registered write-back cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// MUL   | 32 shift-add iterations, then sign fix and result select
// DIV   | 32 restoring-divide iterations (or immediate exit for /0 and overflow)
// DONE  | one-cycle write-back pulse on done/rd_address/rd_data
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        flush,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_address,
   output logic [31:0] rd_data
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;

   logic [2:0]  op_q;
   logic [4:0]  rd_q;
   logic [31:0] a_raw_q;
   logic [63:0] acc_q;      // mul: running product; div: {remainder, quotient}
   logic [63:0] sh_a_q;     // mul: shifted multiplicand magnitude
   logic [31:0] sh_b_q;     // mul: multiplier magnitude; div: divisor magnitude
   logic [5:0]  cnt_q;      // iterations remaining
   logic        neg_q_q;    // negate product / quotient
   logic        neg_r_q;    // negate remainder
   logic        div0_q;
   logic        ovf_q;

   logic        done_d;
   logic [4:0]  rd_address_d;
   logic [31:0] rd_data_d;

   logic        a_signed, b_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        accept;

   logic [32:0] div_trial, div_diff;
   logic [63:0] prod_s;
   logic [31:0] quot_s, rem_s;
   logic [31:0] mul_result, div_result;

   // operand sign handling at capture time
   always_comb begin
      a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
      a_neg    = a_signed & rs1_data[31];
      b_neg    = b_signed & rs2_data[31];
      a_mag    = a_neg ? (32'd0 - rs1_data) : rs1_data;
      b_mag    = b_neg ? (32'd0 - rs2_data) : rs2_data;
      accept   = (state_q == S_IDLE) && start && !flush;
   end

   // restoring divide step and final result formation
   always_comb begin
      div_trial  = acc_q[63:31];
      div_diff   = div_trial - {1'b0, sh_b_q};
      prod_s     = neg_q_q ? (64'd0 - acc_q) : acc_q;
      quot_s     = neg_q_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      rem_s      = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      mul_result = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
      if (div0_q)
         div_result = op_q[1] ? a_raw_q : 32'hFFFF_FFFF;
      else if (ovf_q)
         div_result = op_q[1] ? 32'd0 : 32'h8000_0000;
      else
         div_result = op_q[1] ? rem_s : quot_s;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state and write-back values (registered below)
   always_comb begin
      state_d      = state_q;
      done_d       = 1'b0;
      rd_address_d = 5'd0;
      rd_data_d    = 32'd0;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start) state_d = funct3[2] ? S_DIV : S_MUL;
            S_MUL: begin
               if (cnt_q == 6'd0) begin
                  state_d      = S_DONE;
                  done_d       = 1'b1;
                  rd_address_d = rd_q;
                  rd_data_d    = mul_result;
               end
            end
            S_DIV: begin
               if (div0_q || ovf_q || cnt_q == 6'd0) begin
                  state_d      = S_DONE;
                  done_d       = 1'b1;
                  rd_address_d = rd_q;
                  rd_data_d    = div_result;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // operand capture and per-cycle iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= 3'd0;
         rd_q    <= 5'd0;
         a_raw_q <= 32'd0;
         acc_q   <= 64'd0;
         sh_a_q  <= 64'd0;
         sh_b_q  <= 32'd0;
         cnt_q   <= 6'd0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         op_q    <= funct3;
         rd_q    <= rd_in;
         a_raw_q <= rs1_data;
         acc_q   <= funct3[2] ? {32'd0, a_mag} : 64'd0;
         sh_a_q  <= {32'd0, a_mag};
         sh_b_q  <= b_mag;
         cnt_q   <= 6'd32;
         neg_q_q <= a_neg ^ b_neg;
         neg_r_q <= a_neg;
         div0_q  <= funct3[2] && (rs2_data == 32'd0);
         ovf_q   <= funct3[2] && !funct3[0] && (rs1_data == 32'h8000_0000)
                    && (rs2_data == 32'hFFFF_FFFF);
      end else if (state_q == S_MUL && cnt_q != 6'd0) begin
         if (sh_b_q[0]) acc_q <= acc_q + sh_a_q;
         sh_a_q <= {sh_a_q[62:0], 1'b0};
         sh_b_q <= {1'b0, sh_b_q[31:1]};
         cnt_q  <= cnt_q - 6'd1;
      end else if (state_q == S_DIV && cnt_q != 6'd0 && !div0_q && !ovf_q) begin
         if (!div_diff[32]) acc_q <= {div_diff[31:0], acc_q[30:0], 1'b1};
         else               acc_q <= {div_trial[31:0], acc_q[30:0], 1'b0};
         cnt_q <= cnt_q - 6'd1;
      end
   end

   // registered write-back outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done       <= 1'b0;
         rd_address <= 5'd0;
         rd_data    <= 32'd0;
      end else begin
         done       <= done_d;
         rd_address <= rd_address_d;
         rd_data    <= rd_data_d;
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 The block SHALL expose: clk  input  1  clock, rising-edge.
REQ-003 The block SHALL expose: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL expose: start  input  1  request to begin an RV32M operation.
REQ-005 The block SHALL expose: flush  input  1  abort the in-flight operation, no write-back.
REQ-006 The block SHALL expose: funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 The block SHALL expose: rs1_data  input  32  operand A.
REQ-008 The block SHALL expose: rs2_data  input  32  operand B.
REQ-009 The block SHALL expose: rd_in  input  5  destination register index.
REQ-010 The block SHALL expose: busy  output  1  operation in progress; start ignored.
REQ-011 The block SHALL expose: done  output  1  result valid, one-cycle pulse.
REQ-012 The block SHALL expose: rd_address  output  5  register-file write index, 0 when not writing.
REQ-013 The block SHALL expose: rd_data  output  32  register-file write data.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, DONE; busy = 1 in MUL, DIV and DONE.
REQ-015 In IDLE with start=1 and flush=0, the block SHALL capture funct3, rd_in, rs1_data and rs2_data on that edge; it SHALL go to MUL for funct3<4 and to DIV otherwise.
REQ-016 start while busy=1 SHALL be ignored, and captured operands SHALL NOT change.
REQ-017 Multiply SHALL be iterative shift-add over operand magnitudes, 1 bit per cycle, 32 cycles, producing a 64-bit product.
REQ-018 Signedness: MUL/MULH signed x signed; MULHSU rs1 signed x rs2 unsigned; MULHU unsigned x unsigned; the product SHALL be negated when the operand signs differ.
REQ-019 Result select: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32].
REQ-020 Divide SHALL be restoring division over magnitudes (DIV/REM signed, DIVU/REMU unsigned), 1 quotient bit per cycle, 32 cycles.
REQ-021 The quotient sign SHALL be the XOR of the operand signs; the remainder sign SHALL follow the dividend.
REQ-022 Divide by zero SHALL skip iteration and go to DONE on the next edge: quotient = 0xFFFFFFFF, remainder = dividend.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM) SHALL skip iteration: quotient = 0x80000000, remainder = 0.
REQ-024 Latency: start accepted at edge N SHALL give done=1 during the cycle after edge N+33 for iterative ops, and after edge N+1 for the REQ-022/023 special cases.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE; start is accepted again in the cycle after DONE.
REQ-026 In DONE, rd_address SHALL equal the captured rd and rd_data the result; in all other states rd_address = 0 and rd_data = 0.
REQ-027 A captured rd of 0 SHALL still run full latency; done pulses with rd_address = 0.
REQ-028 flush=1 in any state SHALL force IDLE on the next edge with no DONE cycle and no write; flush has priority over start in IDLE.
REQ-029 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously enter IDLE and clear all internal registers; busy, done, rd_address and rd_data SHALL all be 0.
REQ-031 Reset mid-operation SHALL discard the operation; no done pulse or write SHALL follow reset release.
REQ-032 After release, start SHALL be accepted on the first rising edge.

Verification
REQ-033 The bench SHALL cover MUL rs1=7, rs2=0xFFFFFFFD, rd=5: done at N+33 with rd_address=5, rd_data=0xFFFFFFEB; busy high for 34 cycles.
REQ-034 The bench SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF: result 0xFFFFFFFE; MULH with the same operands: result 0x00000000; MULHSU 0xFFFFFFFF x 2: result 0xFFFFFFFF.
REQ-035 The bench SHALL cover DIV 0xFFFFFFF9 / 2: result 0xFFFFFFFD; REM with the same operands: result 0xFFFFFFFF; DIVU 100/7: result 14; REMU 100/7: result 2.
REQ-036 The bench SHALL cover DIVU 5/0: result 0xFFFFFFFF at N+1; REM 5/0: result 5; DIV 0x80000000/0xFFFFFFFF: result 0x80000000 at N+1.
REQ-037 The bench SHALL cover start while busy, flush at iteration 10, and rst_n low at iteration 20: no done pulse, rd_address stays 0, next operation is correct.
REQ-038 The bench SHALL cover rd_in=0 with MUL 3x4: done pulses at N+33 with rd_address=0.
